// File: rtl/axis_accum_scheduler.sv
// Round-robin scheduler sharing one frame accumulator between N_REQ AXI-Stream requesters.
// Each grant covers a full NO_OF_STEPS-beat frame; the sum is emitted tagged with the requester id.
module axis_accum_scheduler #(
   parameter int unsigned N_REQ       = 4,
   parameter int unsigned WIDTH       = 3,
   parameter int unsigned NO_OF_STEPS = 10,
   localparam int unsigned ID_W       = $clog2(N_REQ),
   localparam int unsigned W_SUM      = WIDTH + $clog2(NO_OF_STEPS)
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic [N_REQ-1:0]             s_valid,
   output logic [N_REQ-1:0]             s_ready,
   input  logic [N_REQ-1:0][WIDTH-1:0]  s_data,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic [W_SUM-1:0]             m_data,
   output logic [ID_W-1:0]              m_id,
   output logic                         busy
);

   localparam int unsigned CNT_W = $clog2(NO_OF_STEPS);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NO_OF_STEPS - 1);

   typedef enum logic [1:0] {StIdle, StAccum, StOut} state_t;

   state_t             state;
   logic [ID_W-1:0]    grant;
   logic [ID_W-1:0]    last_grant;
   logic [CNT_W-1:0]   count;
   logic [W_SUM-1:0]   sum;

   logic               pick_valid;
   logic [ID_W-1:0]    pick;
   logic [ID_W-1:0]    cand;
   logic [W_SUM-1:0]   beat;
   logic [W_SUM-1:0]   sum_nxt;

   // Search starts just after the last served requester so nobody is favoured by index.
   always_comb begin
      pick_valid = 1'b0;
      pick       = '0;
      cand       = '0;
      for (int unsigned i = 1; i <= N_REQ; i++) begin
         cand = ID_W'((32'(last_grant) + i) % N_REQ);
         if (!pick_valid && s_valid[cand]) begin
            pick_valid = 1'b1;
            pick       = cand;
         end
      end
   end

   always_comb begin
      beat    = W_SUM'(s_data[grant]);
      sum_nxt = (count == '0) ? beat : sum + beat;
   end

   assign busy = (state != StIdle);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= StIdle;
         grant      <= '0;
         last_grant <= ID_W'(N_REQ - 1);
         count      <= '0;
         sum        <= '0;
         s_ready    <= '0;
         m_valid    <= 1'b0;
         m_data     <= '0;
         m_id       <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               if (pick_valid) begin
                  grant   <= pick;
                  count   <= '0;
                  s_ready <= N_REQ'(1) << pick;
                  state   <= StAccum;
               end
            end
            StAccum: begin
               if (s_valid[grant] && s_ready[grant]) begin
                  sum <= sum_nxt;
                  if (count == LAST_CNT) begin
                     count   <= '0;
                     s_ready <= '0;
                     m_valid <= 1'b1;
                     m_data  <= sum_nxt;
                     m_id    <= grant;
                     state   <= StOut;
                  end else begin
                     count <= count + CNT_W'(1);
                  end
               end
            end
            StOut: begin
               if (m_ready) begin
                  m_valid    <= 1'b0;
                  last_grant <= grant;
                  state      <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_axis_accum_scheduler.sv
// Bench for axis_accum_scheduler: per-cycle behavioural model plus directed and random frames.
module tb_axis_accum_scheduler;

   localparam int N_REQ = 4;
   localparam int WIDTH = 8;
   localparam int STEPS = 10;
   localparam int ID_W  = 2;
   localparam int W_SUM = 12;

   logic                        clk = 1'b0;
   logic                        rstn = 1'b0;
   logic [N_REQ-1:0]            s_valid = '0;
   logic [N_REQ-1:0]            s_ready;
   logic [N_REQ-1:0][WIDTH-1:0] s_data = '0;
   logic                        m_valid;
   logic                        m_ready = 1'b1;
   logic [W_SUM-1:0]            m_data;
   logic [ID_W-1:0]             m_id;
   logic                        busy;

   axis_accum_scheduler #(
      .N_REQ      (N_REQ),
      .WIDTH      (WIDTH),
      .NO_OF_STEPS(STEPS)
   ) dut (
      .clk    (clk),
      .rstn   (rstn),
      .s_valid(s_valid),
      .s_ready(s_ready),
      .s_data (s_data),
      .m_valid(m_valid),
      .m_ready(m_ready),
      .m_data (m_data),
      .m_id   (m_id),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   typedef struct {int id; int data; int cyc;} res_t;
   res_t log_q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int mv_cnt = 0;
   int first_v = -1;
   int q[N_REQ][$];            // per-requester beat queues; -1 marks a one-cycle bubble
   logic [N_REQ-1:0] took = '0;

   // Model: 0 waiting, 1 collecting a frame, 2 presenting a result
   int md_st, md_g, md_lg, md_cnt, md_acc;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (!rstn) begin
         chk("rst_s_ready", s_ready, 0);
         chk("rst_m_valid", m_valid, 0);
         chk("rst_m_data", m_data, 0);
         chk("rst_m_id", m_id, 0);
         chk("rst_busy", busy, 0);
         md_st = 0; md_g = 0; md_lg = N_REQ - 1; md_cnt = 0; md_acc = 0;
         took = '0;
      end else begin
         chk("s_ready", s_ready, (md_st == 1) ? (1 << md_g) : 0);
         chk("m_valid", m_valid, (md_st == 2) ? 1 : 0);
         chk("busy", busy, (md_st != 0) ? 1 : 0);
         if (md_st == 2) begin
            chk("m_data", m_data, md_acc);
            chk("m_id", m_id, md_g);
         end
         chk("s_ready_onehot", ($countones(s_ready) <= 1) ? 1 : 0, 1);
         if (m_valid) mv_cnt++;
         if (s_valid != 0 && first_v < 0) first_v = cyc;
         if (m_valid && m_ready) log_q.push_back('{int'(m_id), int'(m_data), cyc});
         took = s_valid & s_ready;
         case (md_st)
            0: begin
               for (int k = 1; k <= N_REQ; k++) begin
                  int c;
                  c = (md_lg + k) % N_REQ;
                  if (md_st == 0 && s_valid[c]) begin
                     md_g = c; md_cnt = 0; md_st = 1;
                  end
               end
            end
            1: begin
               if (s_valid[md_g]) begin
                  md_acc = (md_cnt == 0) ? int'(s_data[md_g]) : md_acc + int'(s_data[md_g]);
                  md_cnt++;
                  if (md_cnt == STEPS) begin
                     md_cnt = 0; md_st = 2;
                  end
               end
            end
            default: begin
               if (m_ready) begin
                  md_lg = md_g; md_st = 0;
               end
            end
         endcase
      end
   end

   // Source driver: pops accepted beats and expired bubbles, presents the next queue head.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         for (int r = 0; r < N_REQ; r++) begin
            if (q[r].size() > 0 && (took[r] || q[r][0] < 0)) void'(q[r].pop_front());
            if (q[r].size() > 0 && q[r][0] >= 0) begin
               s_valid[r] = 1'b1;
               s_data[r]  = 8'(q[r][0]);
            end else begin
               s_valid[r] = 1'b0;
               s_data[r]  = 8'($urandom_range(0, 255));
            end
         end
      end
   end

   task automatic do_reset();
      @(posedge clk); #2;
      rstn = 1'b0;
      for (int r = 0; r < N_REQ; r++) q[r].delete();
      m_ready = 1'b1;
      @(posedge clk); #2;
      rstn = 1'b1;
      log_q.delete();
      mv_cnt  = 0;
      first_v = -1;
   endtask

   task automatic wait_log(input int n);
      for (int i = 0; i < 600 && log_q.size() < n; i++) @(negedge clk);
      chk("result_count", log_q.size(), n);
   endtask

   task automatic chk_res(input int i, input int id, input int data);
      if (log_q.size() > i) begin
         chk("res_id", log_q[i].id, id);
         chk("res_data", log_q[i].data, data);
      end
   endtask

   initial begin
      int eid[4];
      int edat[4];
      longint total;
      longint got;
      int nframes;
      int r;

      // Reset state
      repeat (2) @(posedge clk);
      #2 rstn = 1'b1;

      // 1: single requester, values 1..10
      do_reset();
      for (int v = 1; v <= 10; v++) q[2].push_back(v);
      wait_log(1);
      chk_res(0, 2, 55);
      if (log_q.size() > 0) chk("frame_cycles", log_q[0].cyc - first_v + 1, 12);
      repeat (2) @(negedge clk);
      chk("mvalid_cycles", mv_cnt, 1);

      // 2: round robin among 0, 1, 3
      do_reset();
      for (int v = 0; v < 20; v++) q[0].push_back(1);
      for (int v = 0; v < 10; v++) q[1].push_back(2);
      for (int v = 0; v < 10; v++) q[3].push_back(4);
      eid  = '{0, 1, 3, 0};
      edat = '{10, 20, 40, 10};
      wait_log(4);
      for (int i = 0; i < 4; i++) chk_res(i, eid[i], edat[i]);

      // 3: backpressure for 5 OUT cycles
      do_reset();
      m_ready = 1'b0;
      for (int v = 0; v < 10; v++) q[0].push_back(3);
      for (int i = 0; i < 100 && !m_valid; i++) @(negedge clk);
      chk("bp_reach_out", m_valid, 1);
      for (int k = 0; k < 5; k++) begin
         chk("bp_m_valid", m_valid, 1);
         chk("bp_m_data", m_data, 30);
         chk("bp_m_id", m_id, 0);
         chk("bp_s_ready", s_ready, 0);
         if (k < 4) @(negedge clk);
      end
      @(posedge clk); #2 m_ready = 1'b1;
      @(negedge clk);
      chk("bp_sixth_valid", m_valid, 1);
      @(negedge clk);
      chk("bp_idle_busy", busy, 0);
      chk("bp_idle_valid", m_valid, 0);
      chk("bp_one_result", log_q.size(), 1);

      // 4: bubbles mid-frame
      do_reset();
      for (int v = 0; v < 5; v++) q[1].push_back(7);
      for (int v = 0; v < 3; v++) q[1].push_back(-1);
      for (int v = 0; v < 5; v++) q[1].push_back(7);
      wait_log(1);
      chk_res(0, 1, 70);

      // 5: maximum values
      do_reset();
      for (int v = 0; v < 10; v++) q[3].push_back(255);
      wait_log(1);
      chk_res(0, 3, 2550);

      // 6: reset mid-frame discards the partial sum
      do_reset();
      for (int v = 1; v <= 5; v++) q[1].push_back(v);
      for (int i = 0; i < 100 && q[1].size() > 0; i++) @(negedge clk);
      chk("rst6_beats_taken", q[1].size(), 0);
      @(posedge clk); #2 rstn = 1'b0;
      @(negedge clk);
      chk("rst6_m_valid", m_valid, 0);
      chk("rst6_s_ready", s_ready, 0);
      chk("rst6_busy", busy, 0);
      chk("rst6_m_data", m_data, 0);
      @(posedge clk); #2 rstn = 1'b1;
      for (int v = 1; v <= 10; v++) q[1].push_back(v);
      wait_log(1);
      chk_res(0, 1, 55);
      repeat (3) @(negedge clk);
      chk("rst6_single_result", log_q.size(), 1);

      // Random frames, bubbles and backpressure
      do_reset();
      total   = 0;
      nframes = 30;
      for (int f = 0; f < nframes; f++) begin
         r = $urandom_range(0, N_REQ - 1);
         for (int b = 0; b < STEPS; b++) begin
            int v;
            v = $urandom_range(0, 255);
            total += v;
            q[r].push_back(v);
            if (b < STEPS - 1 && $urandom_range(0, 3) == 0) q[r].push_back(-1);
         end
      end
      for (int i = 0; i < 20000; i++) begin
         if (q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0 && q[3].size() == 0
             && md_st == 0 && i > 0) break;
         @(posedge clk); #2 m_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #2 m_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rand_frames", log_q.size(), nframes);
      got = 0;
      foreach (log_q[i]) got += log_q[i].data;
      chk("rand_total", got, total);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axis_accum_scheduler.md
# axis_accum_scheduler

Round-robin scheduler that shares one frame accumulator between N_REQ AXI-Stream requesters. It grants the accumulator to one requester for a whole frame of NO_OF_STEPS beats, then presents the unsigned frame sum on an AXI-Stream master port, tagged with the requester index. It sits between the per-channel sample sources and the downstream result consumer, replacing one accumulator per channel.

## Interface

**Parameters**
- N_REQ, 4, number of requesters; minimum 2.
- WIDTH, 3, unsigned sample width.
- NO_OF_STEPS, 10, beats per frame; minimum 2.
- ID_W, derived, $clog2(N_REQ).
- W_SUM, derived, WIDTH + $clog2(NO_OF_STEPS).

**Ports**
- clk, in, 1, clock.
- rstn, in, 1, asynchronous active-low reset.
- s_valid, in, N_REQ, per-requester data valid.
- s_ready, out, N_REQ, per-requester ready; at most one bit is high.
- s_data, in, N_REQ x WIDTH, per-requester sample.
- m_valid, out, 1, result valid.
- m_ready, in, 1, downstream ready.
- m_data, out, W_SUM, frame sum.
- m_id, out, ID_W, index of the requester that produced m_data.
- busy, out, 1, high whenever the state is not IDLE.

## Operation

**FSM states:** IDLE, ACCUM, OUT.

**IDLE**
- s_ready is all zero and m_valid is 0.
- If any s_valid is high, pick the first requester with valid high, searching from last_grant+1 upward with wrap.
- Register the pick as grant, clear count, and move to ACCUM.
- With no requests, stay in IDLE.

**ACCUM**
- s_ready[grant] = 1; all other s_ready bits are 0.
- A beat is accepted when s_valid[grant] & s_ready[grant].
- On each accepted beat:
  - sum <= (count==0) ? s_data[grant] : sum + s_data[grant], zero-extended to W_SUM.
  - count increments.
- When the beat with count==NO_OF_STEPS-1 is accepted, count wraps to 0 and the state moves to OUT.
- Cycles with s_valid[grant] low are bubbles: sum and count hold.
- Valid from other requesters is ignored. They wait and are not dropped.

**OUT**
- m_valid = 1, m_data = sum, m_id = grant.
- All three outputs stay stable until m_ready is seen high.
- On the m_valid & m_ready handshake: last_grant <= grant, then go to IDLE.
- s_ready is all zero throughout OUT.

**Arithmetic**
- Unsigned. W_SUM holds NO_OF_STEPS*(2^WIDTH-1) without overflow, so no saturation is needed.

**Fairness**
- A requester that held valid high is granted within N_REQ-1 other frames.

## Timing

**Reset values** (asynchronous on rstn low)
- state = IDLE, grant = 0, last_grant = N_REQ-1 (so requester 0 wins first), count = 0, sum = 0.
- Outputs: m_valid = 0, m_data = 0, m_id = 0, s_ready = 0, busy = 0.

**Latency**
- Request seen in IDLE at cycle t → s_ready[grant] high at cycle t+1.
- Last beat accepted at cycle t → m_valid high at cycle t+1.
- With no bubbles and m_ready held high, one frame takes NO_OF_STEPS+2 cycles: 1 IDLE, NO_OF_STEPS ACCUM, 1 OUT.
- The next frame's arbitration happens the cycle after the output handshake. There is no IDLE bypass.

**Boundary conditions**
- Simultaneous requests: round-robin order only; requester index gives no fixed priority.
- A requester that drops valid mid-frame keeps the grant; the partial sum holds until it resumes.
- m_ready high on the first OUT cycle: handshake completes in that cycle.
- m_ready held low: OUT persists indefinitely with m_data stable.
- Reset mid-frame or during OUT: the partial or pending result is discarded and never emitted; the next grant after reset goes to requester 0 if it is requesting.

## Test plan

Bench parameters: WIDTH=8, NO_OF_STEPS=10, N_REQ=4.

1. **Single requester:** requester 2 streams 1..10 back-to-back with m_ready=1 → m_data=55, m_id=2, m_valid exactly 1 cycle, 12 cycles from first s_valid to handshake.
2. **Round robin:** requesters 0, 1, 3 all hold valid, each sending constant value 1+index → results in order id 0 (10), 1 (20), 3 (40), then 0 again; s_ready is never high for more than one bit.
3. **Backpressure:** m_ready low for 5 cycles during OUT → m_data and m_id stable, m_valid held, all s_ready 0; handshake on the 6th cycle, then IDLE.
4. **Bubbles:** granted requester inserts 3 idle cycles mid-frame, all data 7 → m_data=70; count and sum unchanged during the bubbles.
5. **Maximum values:** all beats 255 → m_data=2550 with no wrap.
6. **Reset mid-frame:** rstn pulsed low after beat 5 of requester 1 → no m_valid for that frame; all outputs at reset values; the next frame, from requester 1 sending 1..10, gives 55.
